// File: rtl/prueba_adc_ipd_trunk_pkg.sv
// Shared types and widths for the serial ADC front end and I-PD controller.
// Used by both builds of the top (with and without IPD_DERIV_EN).
package prueba_adc_ipd_trunk_pkg;

    typedef enum logic [1:0] {
        StQuiet = 2'd0,
        StConv  = 2'd1,
        StDone  = 2'd2
    } adc_state_e;

    localparam int ADC_BITS   = 12;
    localparam int FRAME_BITS = 16;
    localparam int OUT_BITS   = 12;
    localparam int ACC_BITS   = 32;

    localparam logic signed [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS - 1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS - 1){1'b0}}};

    // Clamp a one-bit-wider sum back into the accumulator range.
    function automatic logic signed [ACC_BITS-1:0] sat_acc(input logic signed [ACC_BITS:0] x);
        logic signed [ACC_BITS-1:0] r;
        r = x[ACC_BITS-1:0];
        if (x[ACC_BITS] != x[ACC_BITS-1]) begin
            r = x[ACC_BITS] ? ACC_MIN : ACC_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/prueba_adc_ipd_trunk_adc_serial_rx.sv
// Free-running serial ADC reader: QUIET/CONV/DONE sequencing, SClk and CS generation,
// 16-bit capture shift register and one-cycle sample strobe (asserted in DONE).
module prueba_adc_ipd_trunk_adc_serial_rx
    import prueba_adc_ipd_trunk_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                i_data,
    output logic                o_sclk,
    output logic                o_cs,
    output logic [ADC_BITS-1:0] o_y,
    output logic                o_sample,
    output logic [ADC_BITS-1:0] o_dato
);

    localparam int unsigned CW = $clog2(4 * CLK_DIV) + 1;
    localparam logic [CW-1:0] QUIET_LAST = CW'(4 * CLK_DIV - 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);

    adc_state_e            r_state;
    adc_state_e            w_state_next;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_next;
    logic                  r_sclk;
    logic                  w_sclk_next;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] w_shift_next;
    logic [ADC_BITS-1:0]   r_dato;

    // A marker bit loaded on CONV entry reaches the MSB after 15 shifts, so the
    // shift register itself signals the last rising edge of the frame.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_sclk_next  = r_sclk;
        w_shift_next = r_shift;
        case (r_state)
            StQuiet: begin
                w_sclk_next = 1'b1;
                if (r_cnt == QUIET_LAST) begin
                    w_state_next = StConv;
                    w_cnt_next   = '0;
                    w_shift_next = FRAME_BITS'(1);
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StConv: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt_next  = '0;
                    w_sclk_next = ~r_sclk;
                    if (!r_sclk) begin
                        w_shift_next = {r_shift[FRAME_BITS-2:0], i_data};
                        if (r_shift[FRAME_BITS-1]) begin
                            w_state_next = StDone;
                        end
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StDone: begin
                // DONE is the first cycle of the CS-high window.
                w_state_next = StQuiet;
                w_cnt_next   = CW'(1);
            end
            default: begin
                w_state_next = StQuiet;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_state <= StQuiet;
            r_cnt   <= '0;
            r_sclk  <= 1'b1;
            r_shift <= '0;
            r_dato  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_sclk  <= w_sclk_next;
            r_shift <= w_shift_next;
            if (r_state == StDone) begin
                r_dato <= r_shift[ADC_BITS-1:0];
            end
        end
    end

    assign o_sclk   = r_sclk;
    assign o_cs     = (r_state != StConv);
    assign o_y      = r_shift[ADC_BITS-1:0];
    assign o_sample = (r_state == StDone);
    assign o_dato   = r_dato;

endmodule

// File: rtl/prueba_adc_ipd_trunk.sv
// Serial ADC front end driving a 3-stage I-PD controller with truncated, clamped output.
// Define IPD_DERIV_EN to include the derivative-on-measurement term.
module prueba_adc_ipd_trunk
    import prueba_adc_ipd_trunk_pkg::*;
#(
    parameter int unsigned        CLK_DIV  = 4,
    parameter int unsigned        SETPOINT = 2048,
    parameter logic signed [15:0] KP       = 16'sd256,
    parameter logic signed [15:0] KI       = 16'sd16,
    parameter logic signed [15:0] KD       = 16'sd64,
    parameter int unsigned        FRAC     = 8
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                DataIn,
    output logic                SClk,
    output logic                CS,
    output logic [ADC_BITS-1:0] Dato_ADC,
    output logic [OUT_BITS-1:0] U,
    output logic                U_Valid
);

    localparam int unsigned ERR_W  = ADC_BITS + 1;
    localparam int unsigned PROD_W = $bits(KD) + ERR_W;
    localparam int unsigned SUM_W  = ACC_BITS + 2;
    localparam logic signed [ERR_W-1:0] SP_S = $signed({1'b0, ADC_BITS'(SETPOINT)});

    logic                     w_sample;
    logic [ADC_BITS-1:0]      w_y;
    logic signed [ERR_W-1:0]  w_y_s;

    logic                     r_s1_valid;
    logic signed [ERR_W-1:0]  r_y;
    logic signed [ERR_W-1:0]  r_e;
    logic                     r_s2_valid;
    logic signed [PROD_W-1:0] r_ie;
    logic signed [PROD_W-1:0] r_p;
    logic signed [PROD_W-1:0] w_d;

    logic signed [ACC_BITS-1:0] r_acc;
    logic signed [ACC_BITS:0]   w_acc_sum;
    logic signed [ACC_BITS-1:0] w_acc_sat;
    logic signed [SUM_W-1:0]    w_sum;
    logic signed [SUM_W-1:0]    w_shr;
    logic [OUT_BITS-1:0]        w_u_next;
    logic [OUT_BITS-1:0]        r_u;
    logic                       r_u_valid;

    prueba_adc_ipd_trunk_adc_serial_rx #(
        .CLK_DIV(CLK_DIV)
    ) u_rx (
        .Clk     (Clk),
        .Rest    (Rest),
        .i_data  (DataIn),
        .o_sclk  (SClk),
        .o_cs    (CS),
        .o_y     (w_y),
        .o_sample(w_sample),
        .o_dato  (Dato_ADC)
    );

    assign w_y_s = $signed({1'b0, w_y});

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_s1_valid <= 1'b0;
            r_y        <= '0;
            r_e        <= '0;
        end else begin
            r_s1_valid <= w_sample;
            if (w_sample) begin
                r_y <= w_y_s;
                r_e <= SP_S - w_y_s;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_s2_valid <= 1'b0;
            r_ie       <= '0;
            r_p        <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_ie <= PROD_W'(KI) * PROD_W'(r_e);
                r_p  <= PROD_W'(KP) * PROD_W'(r_y);
            end
        end
    end

`ifdef IPD_DERIV_EN
    logic signed [ERR_W-1:0]  r_y_prev;
    logic signed [ERR_W-1:0]  r_dy;
    logic signed [PROD_W-1:0] r_d;

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_y_prev <= '0;
            r_dy     <= '0;
            r_d      <= '0;
        end else begin
            if (w_sample) begin
                r_dy     <= w_y_s - r_y_prev;
                r_y_prev <= w_y_s;
            end
            if (r_s1_valid) begin
                r_d <= PROD_W'(KD) * PROD_W'(r_dy);
            end
        end
    end

    assign w_d = r_d;
`else
    assign w_d = '0;
`endif

    assign w_acc_sum = (ACC_BITS + 1)'(r_acc) + (ACC_BITS + 1)'(r_ie);
    assign w_acc_sat = sat_acc(w_acc_sum);
    assign w_sum     = SUM_W'(w_acc_sat) - SUM_W'(r_p) - SUM_W'(w_d);
    assign w_shr     = w_sum >>> FRAC;

    always_comb begin
        w_u_next = w_shr[OUT_BITS-1:0];
        if (w_shr[SUM_W-1]) begin
            w_u_next = '0;
        end else if (|w_shr[SUM_W-2:OUT_BITS]) begin
            w_u_next = '1;
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_acc     <= '0;
            r_u       <= '0;
            r_u_valid <= 1'b0;
        end else begin
            r_u_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_acc <= w_acc_sat;
                r_u   <= w_u_next;
            end
        end
    end

    assign U       = r_u;
    assign U_Valid = r_u_valid;

endmodule

// File: tb/tb_prueba_adc_ipd_trunk.sv
// Directed bench for prueba_adc_ipd_trunk: frames are shifted in MSB first, expected
// samples/outputs go through a scoreboard queue and are checked on each U_Valid pulse.
module tb_prueba_adc_ipd_trunk;

    localparam int     CLK_DIV  = 4;
    localparam longint SETPOINT = 2048;
    localparam longint KP       = 256;
    localparam longint KI       = 16;
    localparam longint KD       = 64;
    localparam int     FRAC     = 8;
    localparam longint ACC_MAX  = 2147483647;
    localparam longint ACC_MIN  = -ACC_MAX - 1;
`ifdef IPD_DERIV_EN
    localparam bit DERIV = 1'b1;
`else
    localparam bit DERIV = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rest;
    logic        DataIn;
    logic        SClk;
    logic        CS;
    logic [11:0] Dato_ADC;
    logic [11:0] U;
    logic        U_Valid;

    typedef struct packed {
        logic [11:0] dato;
        logic [11:0] u;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] tb_frame = 16'h0000;
    int          tb_bit   = 15;
    longint      m_acc    = 0;
    longint      m_yprev  = 0;
    bit          tb_chain = 1'b0;
    logic [11:0] last_u   = '0;

    initial forever #5 Clk = ~Clk;

    prueba_adc_ipd_trunk dut (
        .Clk     (Clk),
        .Rest    (Rest),
        .DataIn  (DataIn),
        .SClk    (SClk),
        .CS      (CS),
        .Dato_ADC(Dato_ADC),
        .U       (U),
        .U_Valid (U_Valid)
    );

    // Present the next frame bit on each SClk falling edge; CS rising re-arms the frame.
    initial begin
        DataIn = 1'b0;
        forever begin
            @(negedge SClk or posedge CS);
            if (CS === 1'b1) begin
                tb_bit = 15;
            end else if (tb_bit >= 0) begin
                DataIn = tb_frame[tb_bit];
                tb_bit = tb_bit - 1;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input longint y, output logic [11:0] u_exp);
        longint e, p, d, sum, s;
        e     = SETPOINT - y;
        m_acc = m_acc + KI * e;
        if (m_acc > ACC_MAX) m_acc = ACC_MAX;
        if (m_acc < ACC_MIN) m_acc = ACC_MIN;
        p       = KP * y;
        d       = DERIV ? KD * (y - m_yprev) : 0;
        m_yprev = y;
        sum     = m_acc - p - d;
        s       = sum >>> FRAC;
        if (s < 0) u_exp = 12'd0;
        else if (s > 4095) u_exp = 12'd4095;
        else u_exp = s[11:0];
    endtask

    task automatic wait_first_conv();
        int n;
        n = 0;
        while (CS !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check("quiet_after_reset", n, 4 * CLK_DIV);
    endtask

    task automatic run_frame(input logic [15:0] f);
        exp_t        ex;
        logic [11:0] u_exp;
        int          n;
        tb_frame = f;
        model_step(longint'(f[11:0]), u_exp);
        sb_q.push_back('{dato: f[11:0], u: u_exp});
        n = 0;
        while (CS !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        check("cs_fall", CS, 0);
        if (CS !== 1'b0) begin
            sb_q.delete();
            return;
        end
        if (tb_chain) check("cs_high_cycles", n + 4, 16);
        n = 0;
        while (CS === 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check("cs_low_cycles", n, 128);
        n = 0;
        while (U_Valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("u_valid_latency", n, 3);
        check("sb_depth", sb_q.size(), 1);
        ex = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        check("dato_adc", Dato_ADC, ex.dato);
        check("u_out", U, ex.u);
        last_u = U;
        tick();
        check("u_valid_pulse", U_Valid, 0);
        check("u_hold", U, last_u);
        tb_chain = 1'b1;
    endtask

    initial begin
        int n;
        Rest = 1'b0;
        repeat (3) tick();
        check("rst_cs", CS, 1);
        check("rst_sclk", SClk, 1);
        check("rst_dato", Dato_ADC, 0);
        check("rst_u", U, 0);
        check("rst_u_valid", U_Valid, 0);

        tb_frame = 16'h0000;
        @(negedge Clk);
        Rest = 1'b1;
        wait_first_conv();

        run_frame(16'h0000);
        check("zero_u1", last_u, 128);
        run_frame(16'h0000);
        check("zero_u2", last_u, 256);
        run_frame(16'hFFFF);
        check("ones_u1", last_u, 0);
        run_frame(16'hFFFF);
        check("ones_u2", last_u, 0);
        run_frame(16'h0800);
        check("setpoint_u", last_u, 0);
        // Leading bits set must be ignored.
        run_frame(16'hF064);
        run_frame(16'hF064);
        for (int i = 0; i < 32; i++) run_frame(16'h0000);
        check("u_clamp_high", last_u, 4095);
        run_frame(16'h0800);
        check("pre_reset_u_nonzero", (last_u != 12'd0), 1);

        // Abort a frame part-way through CONV while SClk is low.
        tb_frame = 16'hA5A5;
        n = 0;
        while (CS !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        repeat (20) tick();
        n = 0;
        while (SClk !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        check("pre_reset_sclk_low", SClk, 0);
        #2 Rest = 1'b0;
        #1;
        check("async_rst_cs", CS, 1);
        check("async_rst_sclk", SClk, 1);
        check("async_rst_u", U, 0);
        check("async_rst_dato", Dato_ADC, 0);
        check("async_rst_u_valid", U_Valid, 0);
        sb_q.delete();
        m_acc    = 0;
        m_yprev  = 0;
        tb_chain = 1'b0;
        tb_frame = 16'h0000;
        repeat (2) @(negedge Clk);
        Rest = 1'b1;
        wait_first_conv();
        check("post_reset_dato", Dato_ADC, 0);
        run_frame(16'h0000);
        check("post_reset_u", last_u, 128);
        run_frame(16'h0ABC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
